// File: rtl/subservient_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : subservient_loader_pkg
//  Purpose  : Shared types and helpers for the subservient debug-port loader.
//             Holds the loader state encoding, the word geometry and the
//             lane-count to byte-enable mapping.
//  Revision : 1.0  initial release
// ============================================================================
package subservient_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_t;

  // Number of filled lanes (0..4) to Wishbone byte enables.
  function automatic logic [3:0] sel_from_count(input logic [2:0] count);
    logic [3:0] sel;
    case (count)
      3'd1:    sel = 4'b0001;
      3'd2:    sel = 4'b0011;
      3'd3:    sel = 4'b0111;
      3'd4:    sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/subservient_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : subservient_byte_packer
//  Purpose  : Packs a byte stream little-endian into a 32-bit word. Byte k of
//             a word lands in bits [8k+7:8k].
//  Ports    : i_clk, i_rst      clock, synchronous active-high reset
//             i_clr             discard the current word (wins over i_push)
//             i_push, i_byte    insert i_byte into the next free lane
//             o_word            packed word (unfilled lanes read as 0)
//             o_count           number of filled lanes, 0..4
//             o_full            all four lanes filled
//             o_sel             byte-enable mask of the filled lanes
//  Revision : 1.0  initial release
// ============================================================================
module subservient_byte_packer
  import subservient_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [2:0]  o_count,
  output logic        o_full,
  output logic [3:0]  o_sel
);

  logic [31:0] r_word;
  logic [2:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_word <= 32'h0;
      r_cnt  <= 3'd0;
    end else if (i_push && (r_cnt != 3'(BYTES_PER_WORD))) begin
      r_word[{r_cnt[1:0], 3'b000} +: 8] <= i_byte;
      r_cnt                             <= r_cnt + 3'd1;
    end
  end

  assign o_word  = r_word;
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == 3'(BYTES_PER_WORD));
  assign o_sel   = sel_from_count(r_cnt);

endmodule
`default_nettype wire

// File: rtl/subservient_dbg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : subservient_dbg_loader
//  Purpose  : Wishbone initiator on the subservient debug port. Takes a byte
//             stream, packs it into words and writes them to core SRAM at
//             incrementing word addresses while holding the core in debug
//             mode. Signals completion with a one-cycle done pulse.
//  Ports    : i_clk, i_rst            clock, synchronous active-high reset
//             i_start, i_base_adr,    load request, sampled in IDLE only
//             i_len
//             i_byte_valid, i_byte,   byte stream (valid/ready)
//             o_byte_ready
//             o_busy, o_done, o_sum   status, completion pulse, word checksum
//             o_debug_mode            holds the core in debug mode
//             o_wb_dbg_*, i_wb_dbg_*  Wishbone write master
//  Revision : 1.0  initial release
// ============================================================================
module subservient_dbg_loader
  import subservient_loader_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_adr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_sum,
  output logic             o_debug_mode,
  output logic [31:0]      o_wb_dbg_adr,
  output logic [31:0]      o_wb_dbg_dat,
  output logic [3:0]       o_wb_dbg_sel,
  output logic             o_wb_dbg_we,
  output logic             o_wb_dbg_stb,
  input  logic [31:0]      i_wb_dbg_rdt,
  input  logic             i_wb_dbg_ack
);

  loader_state_t    r_state;
  loader_state_t    w_next;
  logic [31:0]      r_adr;
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_sum;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_ack;
  logic             w_clr;
  logic [31:0]      w_word;
  logic [2:0]       w_count;
  logic             w_full;
  logic [3:0]       w_sel;

  // Read data and the low address bits are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{i_wb_dbg_rdt, i_base_adr[1:0], w_full};

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_accept   = (r_state == S_FILL) && i_byte_valid;
  assign w_ack      = (r_state == S_WRITE) && i_wb_dbg_ack;
  assign w_clr      = w_start_ok || w_ack;

  subservient_byte_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_push  (w_accept),
    .i_byte  (i_byte),
    .o_word  (w_word),
    .o_count (w_count),
    .o_full  (w_full),
    .o_sel   (w_sel)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_byte_ready = 1'b0;
    o_busy       = 1'b0;
    o_debug_mode = 1'b0;
    o_done       = 1'b0;
    o_wb_dbg_stb = 1'b0;
    o_wb_dbg_we  = 1'b0;
    o_wb_dbg_adr = 32'h0;
    o_wb_dbg_dat = 32'h0;
    o_wb_dbg_sel = 4'h0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // A zero-length image never enters debug mode.
          w_next = (i_len == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        o_debug_mode = 1'b1;
        // Lane 3 just filled, or this is the last byte of the image.
        if (w_accept && ((w_count == 3'(BYTES_PER_WORD - 1)) || (r_rem == LEN_W'(1)))) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_busy       = 1'b1;
        o_debug_mode = 1'b1;
        o_wb_dbg_stb = 1'b1;
        o_wb_dbg_we  = 1'b1;
        o_wb_dbg_adr = r_adr;
        o_wb_dbg_dat = w_word;
        o_wb_dbg_sel = w_sel;
        if (i_wb_dbg_ack) begin
          w_next = (r_rem == '0) ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_adr <= 32'h0;
      r_rem <= '0;
      r_sum <= 32'h0;
    end else begin
      if (w_start_ok) begin
        r_adr <= {i_base_adr[31:2], 2'b00};
        r_rem <= i_len;
        r_sum <= 32'h0;
      end
      if (w_accept) begin
        r_rem <= r_rem - LEN_W'(1);
      end
      if (w_ack) begin
        r_sum <= r_sum + w_word;
        r_adr <= r_adr + 32'd4;
      end
    end
  end

  assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_subservient_dbg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subservient_dbg_loader
//  Purpose  : Self-checking bench for subservient_dbg_loader. Each table
//             entry describes one load and the writes/checksum it must
//             produce; a small Wishbone responder acks after a set delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_subservient_dbg_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_base_adr;
  logic [15:0] i_len;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_sum;
  logic        o_debug_mode;
  logic [31:0] o_wb_dbg_adr;
  logic [31:0] o_wb_dbg_dat;
  logic [3:0]  o_wb_dbg_sel;
  logic        o_wb_dbg_we;
  logic        o_wb_dbg_stb;
  logic [31:0] i_wb_dbg_rdt;
  logic        i_wb_dbg_ack;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  subservient_dbg_loader #(.LEN_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_adr   (i_base_adr),
    .i_len        (i_len),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_sum        (o_sum),
    .o_debug_mode (o_debug_mode),
    .o_wb_dbg_adr (o_wb_dbg_adr),
    .o_wb_dbg_dat (o_wb_dbg_dat),
    .o_wb_dbg_sel (o_wb_dbg_sel),
    .o_wb_dbg_we  (o_wb_dbg_we),
    .o_wb_dbg_stb (o_wb_dbg_stb),
    .i_wb_dbg_rdt (i_wb_dbg_rdt),
    .i_wb_dbg_ack (i_wb_dbg_ack)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [7:0]  b0;       // first byte
    logic [7:0]  step;     // byte i = b0 + i*step
    int          delay;    // ack delay in cycles after stb rises
    bit          restart;  // pulse i_start during FILL
    int          rst_at;   // reset instead of acking this write (0 = never)
    int          nwr;
    logic [31:0] f_adr, f_dat;
    logic [3:0]  f_sel;
    logic [31:0] l_adr, l_dat;
    logic [3:0]  l_sel;
    logic [31:0] sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flags"}, {25'd0, o_byte_ready, o_busy, o_done, o_debug_mode,
                            o_wb_dbg_we, o_wb_dbg_stb, |o_wb_dbg_sel}, 32'h0);
    check({tag, "_adr"}, o_wb_dbg_adr, 32'h0);
    check({tag, "_dat"}, o_wb_dbg_dat, 32'h0);
    check({tag, "_sum"}, o_sum, 32'h0);
  endtask

  task automatic run(input vec_t v, input int id);
    int idx = 0, wr = 0, wait_c = 0, dn_cyc = -1, evt_cyc = 0;
    int unstable = 0, rdy_bad = 0, dbg_cyc = 0;
    bit in_wr = 0, fin = 0;
    logic [31:0] f_adr = 0, f_dat = 0, l_adr = 0, l_dat = 0, h_adr = 0, h_dat = 0;
    logic [3:0]  f_sel = 0, l_sel = 0, h_sel = 0;
    string t = $sformatf("v%0d", id);

    i_start    = 1'b1;
    i_len      = v.len;
    i_base_adr = v.base;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(posedge i_clk); #1;
      i_start      = 1'b0;
      i_wb_dbg_ack = 1'b0;
      if (v.restart && c == 3) begin
        i_start = 1'b1;
        i_len   = 16'd2;
      end
      if (o_debug_mode) dbg_cyc++;
      if (o_done) begin
        dn_cyc = c;
        fin    = 1;
      end
      if (o_wb_dbg_stb) begin
        if (o_byte_ready) rdy_bad++;
        if (!in_wr) begin
          in_wr = 1; wait_c = 0;
          h_adr = o_wb_dbg_adr; h_dat = o_wb_dbg_dat; h_sel = o_wb_dbg_sel;
        end else if (h_adr !== o_wb_dbg_adr || h_dat !== o_wb_dbg_dat || h_sel !== o_wb_dbg_sel) begin
          unstable++;
        end
        if (v.rst_at == wr + 1) begin
          i_rst = 1'b1; i_byte_valid = 1'b0;
          @(posedge i_clk); #1;
          i_rst = 1'b0;
          check({t, "_wr_before_rst"}, wr, 1);
          check_idle({t, "_rst"});
          return;
        end else if (wait_c == v.delay) begin
          i_wb_dbg_ack = 1'b1;
          if (wr == 0) begin f_adr = o_wb_dbg_adr; f_dat = o_wb_dbg_dat; f_sel = o_wb_dbg_sel; end
          l_adr = o_wb_dbg_adr; l_dat = o_wb_dbg_dat; l_sel = o_wb_dbg_sel;
          wr++; in_wr = 0; evt_cyc = c;
        end else begin
          wait_c++;
        end
      end
      // Valid is held high for the whole load, even while the loader stalls.
      i_byte_valid = 1'b1;
      i_byte       = v.b0 + v.step * 8'(idx);
      if (o_byte_ready) idx++;
    end
    i_byte_valid = 1'b0;
    i_wb_dbg_ack = 1'b0;

    check({t, "_done_seen"}, 32'(fin), 32'd1);
    check({t, "_done_latency"}, dn_cyc - evt_cyc, 32'd1);
    check({t, "_nwr"}, wr, v.nwr);
    if (v.nwr > 0) begin
      check({t, "_f_adr"}, f_adr, v.f_adr);
      check({t, "_f_dat"}, f_dat, v.f_dat);
      check({t, "_f_sel"}, 32'(f_sel), 32'(v.f_sel));
      check({t, "_l_adr"}, l_adr, v.l_adr);
      check({t, "_l_dat"}, l_dat, v.l_dat);
      check({t, "_l_sel"}, 32'(l_sel), 32'(v.l_sel));
    end
    check({t, "_sum"}, o_sum, v.sum);
    check({t, "_stable"}, unstable, 0);
    check({t, "_ready_in_write"}, rdy_bad, 0);
    check({t, "_dbg_seen"}, 32'(dbg_cyc > 0), 32'(v.len != 0));
    @(posedge i_clk); #1;
    check({t, "_post_done_busy"}, {30'd0, o_done, o_busy}, 32'h0);
  endtask

  vec_t vecs[9];

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_base_adr = 32'h0; i_len = 16'h0;
    i_byte_valid = 1'b0; i_byte = 8'h0; i_wb_dbg_rdt = 32'h0; i_wb_dbg_ack = 1'b0;

    //         base         len   b0     step   dly rs rst nwr f_adr        f_dat        f_sel l_adr        l_dat        l_sel sum
    vecs[0] = '{32'h100,      8, 8'h01, 8'h01, 1, 0, 0, 2, 32'h100,      32'h04030201, 4'hF, 32'h104,      32'h08070605, 4'hF, 32'h0C0A0806};
    vecs[1] = '{32'h203,      6, 8'hAA, 8'h11, 0, 0, 0, 2, 32'h200,      32'hDDCCBBAA, 4'hF, 32'h204,      32'h0000FFEE, 4'h3, 32'hDDCDBB98};
    vecs[2] = '{32'h1000,     4, 8'h10, 8'h10, 5, 0, 0, 1, 32'h1000,     32'h40302010, 4'hF, 32'h1000,     32'h40302010, 4'hF, 32'h40302010};
    vecs[3] = '{32'hFFFFFFFC, 5, 8'h01, 8'h01, 0, 0, 0, 2, 32'hFFFFFFFC, 32'h04030201, 4'hF, 32'h0,        32'h00000005, 4'h1, 32'h04030206};
    vecs[4] = '{32'h40,       7, 8'h01, 8'h01, 2, 0, 0, 2, 32'h40,       32'h04030201, 4'hF, 32'h44,       32'h00070605, 4'h7, 32'h040A0806};
    vecs[5] = '{32'h80,       0, 8'h00, 8'h00, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    vecs[6] = '{32'h100,      8, 8'h01, 8'h01, 1, 1, 0, 2, 32'h100,      32'h04030201, 4'hF, 32'h104,      32'h08070605, 4'hF, 32'h0C0A0806};
    vecs[7] = '{32'h300,      8, 8'h01, 8'h01, 0, 0, 2, 0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    vecs[8] = '{32'h500,      4, 8'h21, 8'h01, 0, 0, 0, 1, 32'h500,      32'h24232221, 4'hF, 32'h500,      32'h24232221, 4'hF, 32'h24232221};

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_idle("reset");

    // A stray ack in IDLE must not start anything.
    i_wb_dbg_ack = 1'b1;
    @(posedge i_clk); #1;
    i_wb_dbg_ack = 1'b0;
    check_idle("stray_ack");

    for (int i = 0; i < 9; i++) begin
      run(vecs[i], i);
      repeat (2) @(posedge i_clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/subservient_dbg_loader.md
# subservient_dbg_loader

Wishbone initiator that drives the subservient debug port (`i_debug_mode`, `i_wb_dbg_*`) to load a program image into core SRAM. It accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words, and issues one Wishbone write per word at incrementing word addresses. It holds the core in debug mode for the whole load and releases it with a done pulse. It sits between the Caravel-side host logic (logic analyzer or management wishbone bridge) and the `subservient_top` debug interface.

## Interface
- `LEN_W`, 16: width of the byte-length input; maximum image size is 2^LEN_W−1 bytes.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_base_adr`  in  32  image base address; bits [1:0] ignored and treated as 0.
- `i_len`  in  LEN_W  image length in bytes; sampled with `i_start`.
- `i_byte_valid`  in  1  stream byte valid.
- `i_byte`  in  8  stream byte.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_busy`  out  1  high from accepted start until done.
- `o_done`  out  1  one-cycle completion pulse.
- `o_sum`  out  32  sum mod 2^32 of all words written in the last load; unwritten lanes count as 0.
- `o_debug_mode`  out  1  to `i_debug_mode`.
- `o_wb_dbg_adr`, `o_wb_dbg_dat`  out  32  Wishbone address and write data.
- `o_wb_dbg_sel`  out  4  byte enables.
- `o_wb_dbg_we`, `o_wb_dbg_stb`  out  1  write enable and strobe.
- `i_wb_dbg_rdt`  in  32  unused.
- `i_wb_dbg_ack`  in  1  Wishbone acknowledge.

## Operation
- Reset values: all outputs 0. `o_sum` clears on reset and on each accepted start.
- States: IDLE, FILL, WRITE, DONE.
- IDLE
  - `i_start` with `i_len`≠0: latch address, set remaining byte count to `i_len`, clear packer; go to FILL. `o_busy` and `o_debug_mode` go high next cycle.
  - `i_start` with `i_len`=0: go to DONE directly. `o_debug_mode` is never asserted.
- FILL
  - `o_byte_ready`=1.
  - Each accepted byte goes into lane `k` (`k`=0..3, lane `k` = bits [8k+7:8k]) and decrements the remaining count.
  - After lane 3 fills, or after the last byte of the image: go to WRITE.
- WRITE
  - `o_byte_ready`=0; `stb`=1, `we`=1.
  - `dat` = packed word; `sel` = mask of filled lanes (4'b1111, or 4'b0001/0011/0111 for a final partial word).
  - `adr`, `dat`, `sel` stay stable until `i_wb_dbg_ack`.
  - On ack: add the word to `o_sum`, advance the address by 4 (wraps mod 2^32), clear the packer. Go to FILL if bytes remain, else DONE.
- DONE: `o_done`=1 for one cycle; `o_busy` and `o_debug_mode` drop in the same cycle. Return to IDLE.
- `i_start` is ignored while busy.
- An `i_wb_dbg_ack` seen outside WRITE is ignored.
- Reset mid-load: next edge returns to IDLE with all outputs 0, which releases debug mode. A partial word in progress is discarded.

## Timing
- Ready-to-accept: a byte is taken on each edge where `i_byte_valid` & `o_byte_ready`. Throughput is 1 byte/cycle in FILL.
- `stb` rises the cycle after the last byte of a word is accepted.
- `stb` falls the cycle after the ack.
- Minimum per word: 4 fill cycles + 1 write cycle when ack is combinational in the same cycle.
- A stalled ack holds WRITE indefinitely; there is no timeout.
- `o_done` comes 1 cycle after the final ack. For `i_len`=0 it comes 1 cycle after start.

## Structure
- Package `subservient_loader_pkg` holds:
  - the state enum (IDLE/FILL/WRITE/DONE);
  - the constant `BYTES_PER_WORD`=4;
  - the function mapping filled-lane count to `sel`.
- Sub-module `subservient_byte_packer`: lane counter, 32-bit shift/insert register, clear input, `full` and `sel` outputs.
- The top-level loader holds the FSM, address/length counters and the sum.

## Test plan
- base=0x100, len=8, bytes 01..08, ack 1 cycle after stb:
  - write adr 0x100, dat 0x04030201, sel F;
  - then write adr 0x104, dat 0x08070605;
  - `o_sum`=0x0C0A0806, single `o_done`.
- len=6, bytes AA BB CC DD EE FF: second write adr base+4, dat 0x0000FFEE, sel 4'b0011.
- len=0 start: `o_done` next cycle, `o_debug_mode` never high, `stb` never high.
- Ack delayed 5 cycles with valid held high: `o_byte_ready`=0 throughout, and `adr`/`dat`/`sel` stay constant until ack.
- `i_rst` during WRITE of the 2nd word: next cycle all outputs 0 and state IDLE. A following start with len=4 performs exactly one write.
- `i_start` pulsed during FILL: ignored, and the write count equals the original `i_len`/4.
